// File: rtl/sr_drive_ctrl.sv
// Conditions raw set/clear request levels into clean, non-overlapping s/r pulses
// for a downstream SR flip-flop, tracking its expected Q and counting conflicts.
module sr_drive_ctrl #(
    parameter int SYNC_STAGES  = 2,
    parameter int DEB_CYCLES   = 4,
    parameter int PULSE_CYCLES = 2,
    parameter int GUARD_CYCLES = 1,
    parameter int PRIORITY     = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       set_req,
    input  logic       clr_req,
    output logic       s,
    output logic       r,
    output logic       busy,
    output logic       q_model,
    output logic [7:0] conflict_cnt
);

    localparam int DW   = $clog2(DEB_CYCLES + 1);
    localparam int SW   = $clog2(SYNC_STAGES + 2);
    localparam int PMAX = (PULSE_CYCLES > GUARD_CYCLES) ? PULSE_CYCLES : GUARD_CYCLES;
    localparam int CW   = $clog2(PMAX + 1);

    typedef enum logic [1:0] {IDLE, SET, CLR, GUARD} state_t;

    logic [1:0]             w_raw;
    logic [SYNC_STAGES-1:0] r_sync [2];
    logic [DW-1:0]          r_debCnt [2];
    logic [1:0]             r_deb;
    logic [1:0]             r_debD;
    logic [SW-1:0]          r_settle;
    logic                   w_settling;
    logic                   w_setEvt;
    logic                   w_clrEvt;

    logic                   r_setPend;
    logic                   r_clrPend;
    logic                   w_setPendNext;
    logic                   w_clrPendNext;
    logic                   w_setKeep;
    logic                   w_clrKeep;
    logic                   w_conflict;
    logic [7:0]             r_conflictCnt;

    state_t                 r_state;
    state_t                 w_nextState;
    logic [CW-1:0]          r_phase;
    logic [CW-1:0]          w_phaseNext;
    logic                   r_s;
    logic                   r_r;
    logic                   r_busy;
    logic                   r_q;

    assign w_raw      = {clr_req, set_req};
    assign w_settling = (r_settle != SW'(SYNC_STAGES + 1));

    // Until the synchronisers have filled after reset, the debounced level simply
    // follows them, so a request already held high at reset release is not an event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_settle <= '0;
            r_deb    <= '0;
            r_debD   <= '0;
            for (int i = 0; i < 2; i++) begin
                r_sync[i]   <= '0;
                r_debCnt[i] <= '0;
            end
        end else begin
            if (w_settling)
                r_settle <= r_settle + SW'(1);
            for (int i = 0; i < 2; i++) begin
                r_sync[i] <= {r_sync[i][SYNC_STAGES-2:0], w_raw[i]};
                if (w_settling) begin
                    r_deb[i]    <= r_sync[i][SYNC_STAGES-1];
                    r_debD[i]   <= r_sync[i][SYNC_STAGES-1];
                    r_debCnt[i] <= '0;
                end else begin
                    r_debD[i] <= r_deb[i];
                    if (r_sync[i][SYNC_STAGES-1] != r_deb[i]) begin
                        if (r_debCnt[i] == DW'(DEB_CYCLES - 1)) begin
                            r_deb[i]    <= ~r_deb[i];
                            r_debCnt[i] <= '0;
                        end else begin
                            r_debCnt[i] <= r_debCnt[i] + DW'(1);
                        end
                    end else begin
                        r_debCnt[i] <= '0;
                    end
                end
            end
        end
    end

    assign w_setEvt = r_deb[0] & ~r_debD[0];
    assign w_clrEvt = r_deb[1] & ~r_debD[1];

    // A flag being accepted this edge is already served, so it cannot be superseded.
    always_comb begin
        w_setKeep     = r_setPend & ~(r_state == IDLE);
        w_clrKeep     = r_clrPend & ~(r_state == IDLE);
        w_setPendNext = w_setKeep;
        w_clrPendNext = w_clrKeep;
        w_conflict    = 1'b0;
        if (w_setEvt && w_clrEvt) begin
            w_conflict    = 1'b1;
            w_setPendNext = (PRIORITY != 0);
            w_clrPendNext = (PRIORITY == 0);
        end else if (w_setEvt) begin
            w_setPendNext = 1'b1;
            if (w_clrKeep) begin
                w_clrPendNext = 1'b0;
                w_conflict    = 1'b1;
            end
        end else if (w_clrEvt) begin
            w_clrPendNext = 1'b1;
            if (w_setKeep) begin
                w_setPendNext = 1'b0;
                w_conflict    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_setPend     <= 1'b0;
            r_clrPend     <= 1'b0;
            r_conflictCnt <= '0;
        end else begin
            r_setPend <= w_setPendNext;
            r_clrPend <= w_clrPendNext;
            if (w_conflict && (r_conflictCnt != 8'hFF))
                r_conflictCnt <= r_conflictCnt + 8'd1;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_phaseNext = r_phase;
        case (r_state)
            IDLE: begin
                w_phaseNext = '0;
                if (r_setPend)
                    w_nextState = SET;
                else if (r_clrPend)
                    w_nextState = CLR;
            end
            SET, CLR: begin
                if (r_phase == CW'(PULSE_CYCLES - 1)) begin
                    w_nextState = GUARD;
                    w_phaseNext = '0;
                end else begin
                    w_phaseNext = r_phase + CW'(1);
                end
            end
            GUARD: begin
                if (r_phase == CW'(GUARD_CYCLES - 1)) begin
                    w_nextState = IDLE;
                    w_phaseNext = '0;
                end else begin
                    w_phaseNext = r_phase + CW'(1);
                end
            end
            default: begin
                w_nextState = IDLE;
                w_phaseNext = '0;
            end
        endcase
    end

    // Drive outputs are registered from the next state so they change cleanly on the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_phase <= '0;
            r_s     <= 1'b0;
            r_r     <= 1'b0;
            r_busy  <= 1'b0;
            r_q     <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_phase <= w_phaseNext;
            r_s     <= (w_nextState == SET);
            r_r     <= (w_nextState == CLR);
            r_busy  <= (w_nextState != IDLE);
            if ((r_state == SET) && (r_phase == '0))
                r_q <= 1'b1;
            else if ((r_state == CLR) && (r_phase == '0))
                r_q <= 1'b0;
        end
    end

    assign s            = r_s;
    assign r            = r_r;
    assign busy         = r_busy;
    assign q_model      = r_q;
    assign conflict_cnt = r_conflictCnt;

endmodule

// File: tb/tb_sr_drive_ctrl.sv
// Directed bench for sr_drive_ctrl: per-cycle output histories are compared
// against hand-computed bit patterns indexed by cycle after the request rise.
module tb_sr_drive_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       set_req = 1'b0;
    logic       clr_req = 1'b0;
    logic       s;
    logic       r;
    logic       busy;
    logic       q_model;
    logic [7:0] conflict_cnt;

    int vectors = 0;
    int miscompares = 0;
    int overlapCount = 0;

    logic [31:0] sHist;
    logic [31:0] rHist;
    logic [31:0] busyHist;
    logic [31:0] qHist;

    sr_drive_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .set_req      (set_req),
        .clr_req      (clr_req),
        .s            (s),
        .r            (r),
        .busy         (busy),
        .q_model      (q_model),
        .conflict_cnt (conflict_cnt)
    );

    // 10 ns clock; outputs are sampled 1 ns after the rising edge
    always #5 clk = ~clk;

    // Watch for the forbidden s=r=1 drive on every cycle of the run
    always @(negedge clk) begin
        if (s && r)
            overlapCount++;
    end

    // Single comparison point for the whole bench
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Reset pulse away from the clock edge, then let the synchronisers settle
    task automatic doReset();
        @(negedge clk);
        set_req = 1'b0;
        clr_req = 1'b0;
        rst_n   = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
    endtask

    // Requests rise in cycle 0; history bit k holds the output seen after edge k
    task automatic applyStimulus(input logic doSet, input logic doClr, input int clrAt, input int dropAt);
        sHist    = '0;
        rHist    = '0;
        busyHist = '0;
        qHist    = '0;
        @(posedge clk);
        #1;
        set_req = doSet;
        clr_req = doClr && (clrAt == 0);
        for (int k = 1; k <= 24; k++) begin
            @(posedge clk);
            #1;
            sHist[k]    = s;
            rHist[k]    = r;
            busyHist[k] = busy;
            qHist[k]    = q_model;
            if (doClr && (k == clrAt))
                clr_req = 1'b1;
            if (k == dropAt) begin
                set_req = 1'b0;
                clr_req = 1'b0;
            end
        end
    endtask

    initial begin
        // Reset values
        #2 rst_n = 1'b0;
        #2;
        checkOutput("reset_outputs", {27'd0, s, r, busy, q_model, 1'b0}, 32'd0);
        checkOutput("reset_cnt", {24'd0, conflict_cnt}, 32'd0);
        #10 rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;

        // Reset in the second SET cycle truncates the pulse immediately
        set_req = 1'b1;
        repeat (9) @(posedge clk);
        #1;
        checkOutput("pre_reset_s_busy_q", {29'd0, s, busy, q_model}, 32'h7);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_drop", {28'd0, s, r, busy, q_model}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        sHist    = '0;
        busyHist = '0;
        for (int k = 1; k <= 24; k++) begin
            @(posedge clk);
            #1;
            sHist[k]    = s;
            busyHist[k] = busy;
        end
        checkOutput("held_after_reset_s", sHist, 32'd0);
        checkOutput("held_after_reset_busy", busyHist, 32'd0);
        set_req = 1'b0;
        repeat (12) @(posedge clk);
        applyStimulus(1'b1, 1'b0, 0, 20);
        checkOutput("rerise_after_reset_s", sHist, 32'h0000_0300);

        // Single set pulse
        doReset();
        applyStimulus(1'b1, 1'b0, 0, 20);
        checkOutput("single_s", sHist, 32'h0000_0300);
        checkOutput("single_r", rHist, 32'd0);
        checkOutput("single_busy", busyHist, 32'h0000_0700);
        checkOutput("single_q", qHist, 32'h01FF_FE00);
        repeat (12) @(posedge clk);

        // Three-cycle glitch is filtered out
        applyStimulus(1'b1, 1'b0, 0, 3);
        checkOutput("glitch_s", sHist, 32'd0);
        checkOutput("glitch_r", rHist, 32'd0);
        checkOutput("glitch_busy", busyHist, 32'd0);
        checkOutput("glitch_q", qHist, 32'h01FF_FFFE);
        checkOutput("glitch_cnt", {24'd0, conflict_cnt}, 32'd0);

        // Simultaneous set and clear: set wins, one conflict
        doReset();
        applyStimulus(1'b1, 1'b1, 0, 20);
        checkOutput("both_s", sHist, 32'h0000_0300);
        checkOutput("both_r", rHist, 32'd0);
        checkOutput("both_q", qHist, 32'h01FF_FE00);
        checkOutput("both_cnt", {24'd0, conflict_cnt}, 32'd1);

        // Clear event during the SET pulse is served straight after the guard
        doReset();
        applyStimulus(1'b1, 1'b1, 3, 20);
        checkOutput("b2b_s", sHist, 32'h0000_0300);
        checkOutput("b2b_r", rHist, 32'h0000_3000);
        checkOutput("b2b_busy", busyHist, 32'h0000_7700);
        checkOutput("b2b_q", qHist, 32'h0000_1E00);
        checkOutput("b2b_cnt", {24'd0, conflict_cnt}, 32'd0);

        // Saturation of the conflict counter
        doReset();
        for (int n = 1; n <= 300; n++) begin
            set_req = 1'b1;
            clr_req = 1'b1;
            repeat (6) @(posedge clk);
            #1;
            set_req = 1'b0;
            clr_req = 1'b0;
            repeat (6) @(posedge clk);
            #1;
            if (n == 254)
                checkOutput("cnt_before_sat", {24'd0, conflict_cnt}, 32'd254);
            if (n == 256)
                checkOutput("cnt_at_sat", {24'd0, conflict_cnt}, 32'd255);
        end
        checkOutput("cnt_holds_sat", {24'd0, conflict_cnt}, 32'd255);
        checkOutput("sat_q", {31'd0, q_model}, 32'd1);

        checkOutput("s_r_never_overlap", overlapCount, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
